act_pipe_arr: RTL and testbench

- Parametrised, pipelined successor to the combinational per-lane ReLU array.
- Applies one of four activation functions to ARRAY_SIZE signed lanes per beat: bypass, ReLU, leaky ReLU (arithmetic-shift slope), or clipped ReLU.
- Two register stages with valid/ready flow control.
- Sits between the systolic accumulator output and the pooling/writeback stage.

---
 rtl/act_pipe_arr.sv | 171 +++++++++++++++++
 tb/tb_act_pipe_arr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/act_pipe_arr.sv
// act_pipe_arr: two-stage pipelined per-lane activation array (bypass / ReLU / leaky / clipped)
// with valid/ready flow control. Define ACT_ZERO_COUNT_EN to add the zero-lane output counter.
module act_pipe_arr #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_SIZE  = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] in_data,
  input  logic [1:0]                       mode,
  input  logic [SHIFT_WIDTH-1:0]           leak_shift,
  input  logic [DATA_WIDTH-1:0]            clip_val,
`ifdef ACT_ZERO_COUNT_EN
  input  logic                             zero_count_clr,
  output logic [31:0]                      zero_count,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] out_data
);

  localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;
  localparam logic signed [DATA_WIDTH-1:0] LANE_ZERO = '0;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLIP   = 2'b11
  } act_mode_e;

  // Clip to zero whenever clip_val is non-positive, otherwise the
  // x > clip branch would pass a negative clip value through.
  function automatic logic signed [DATA_WIDTH-1:0] act_lane(
    input logic signed [DATA_WIDTH-1:0]  x,
    input act_mode_e                     m,
    input logic        [SHIFT_WIDTH-1:0] sh,
    input logic signed [DATA_WIDTH-1:0]  clip
  );
    logic signed [DATA_WIDTH-1:0] y;
    y = x;
    case (m)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = (x > LANE_ZERO) ? x : LANE_ZERO;
      ACT_LEAKY:  y = x[DATA_WIDTH-1] ? (x >>> sh) : x;
      ACT_CLIP: begin
        if ((x <= LANE_ZERO) || (clip <= LANE_ZERO)) y = LANE_ZERO;
        else if (x > clip)                           y = clip;
        else                                         y = x;
      end
      default:    y = x;
    endcase
    return y;
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s2_load;
  logic s1_adv;
  logic accept;

  logic                          vld_p1_q,   vld_p1_d;
  logic [VEC_W-1:0]              data_p1_q,  data_p1_d;
  act_mode_e                     mode_p1_q,  mode_p1_d;
  logic [SHIFT_WIDTH-1:0]        shift_p1_q, shift_p1_d;
  logic signed [DATA_WIDTH-1:0]  clip_p1_q,  clip_p1_d;

  logic                          vld_p2_q,   vld_p2_d;
  logic [VEC_W-1:0]              data_p2_q,  data_p2_d;

  // in_ready depends combinationally on out_ready so a full pipe can accept
  // in the same cycle the downstream drains.
  always_comb begin
    s2_load  = !vld_p2_q || out_ready;
    s1_adv   = vld_p1_q && s2_load;
    in_ready = !vld_p1_q || s2_load;
    accept   = in_valid && in_ready;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture beat and its per-beat function controls
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p1_d   = vld_p1_q;
    data_p1_d  = data_p1_q;
    mode_p1_d  = mode_p1_q;
    shift_p1_d = shift_p1_q;
    clip_p1_d  = clip_p1_q;
    if (accept) begin
      vld_p1_d   = 1'b1;
      data_p1_d  = in_data;
      mode_p1_d  = act_mode_e'(mode);
      shift_p1_d = leak_shift;
      clip_p1_d  = clip_val;
    end else if (s1_adv) begin
      vld_p1_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: apply lane function and register into out_data
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    if (s2_load) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
          data_p2_d[i*DATA_WIDTH +: DATA_WIDTH] =
            act_lane(data_p1_q[i*DATA_WIDTH +: DATA_WIDTH], mode_p1_q, shift_p1_q, clip_p1_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      mode_p1_q  <= ACT_BYPASS;
      shift_p1_q <= '0;
      clip_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      mode_p1_q  <= mode_p1_d;
      shift_p1_q <= shift_p1_d;
      clip_p1_q  <= clip_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;

`ifdef ACT_ZERO_COUNT_EN
  // Zero-lane counter over transferred beats; clear wins over increment.
  function automatic logic [31:0] count_zero_lanes(input logic [VEC_W-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (v[i*DATA_WIDTH +: DATA_WIDTH] == '0) n = n + 32'd1;
    end
    return n;
  endfunction

  logic [31:0] zero_count_q, zero_count_d;

  always_comb begin
    zero_count_d = zero_count_q;
    if (zero_count_clr)              zero_count_d = '0;
    else if (vld_p2_q && out_ready)  zero_count_d = zero_count_q + count_zero_lanes(data_p2_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_count_q <= '0;
    else       zero_count_q <= zero_count_d;
  end

  assign zero_count = zero_count_q;
`endif

endmodule

// File: tb/tb_act_pipe_arr.sv
// Directed testbench for act_pipe_arr (8 lanes x 8 bits, 3-bit leak shift).
module tb_act_pipe_arr;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  mode;
  logic [2:0]  leak_shift;
  logic [7:0]  clip_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
`ifdef ACT_ZERO_COUNT_EN
  logic        zero_count_clr;
  logic [31:0] zero_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] bd [8];
  logic [1:0]  bm [8];
  logic [2:0]  bs [8];
  logic [7:0]  bc [8];
  logic [63:0] be [8];

  always #5 clk = ~clk;

  act_pipe_arr #(.DATA_WIDTH(8), .ARRAY_SIZE(8), .SHIFT_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .leak_shift (leak_shift),
    .clip_val   (clip_val),
`ifdef ACT_ZERO_COUNT_EN
    .zero_count_clr (zero_count_clr),
    .zero_count     (zero_count),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // Single beat with out_ready high: checks 2-cycle latency and result.
  task automatic run_one(input string tag, input logic [1:0] m, input logic [2:0] sh,
                         input logic [7:0] cv, input logic [63:0] d, input logic [63:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; mode = m; leak_shift = sh; clip_val = cv; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_dat"}, out_data, e);
  endtask

  // Streams nb beats from bd/bm/bs/bc back-to-back; out_ready low for the first
  // `stall` cycles. Outputs must match be[] in order with no extras.
  task automatic stream(input int nb, input int stall, input string tag);
    int si, ri, acc_cnt;
    bit acc;
    si = 0; ri = 0; acc_cnt = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 40 && ri < nb; cyc++) begin
      @(negedge clk);
      if (acc) begin si++; acc_cnt++; end
      if (si < nb) begin
        in_valid = 1'b1; in_data = bd[si]; mode = bm[si]; leak_shift = bs[si]; clip_val = bc[si];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc >= stall);
      #1;
      acc = in_valid && in_ready;
      if (stall > 0 && cyc >= 2 && cyc < stall)
        chk($sformatf("%s_hold%0d", tag, cyc), out_data, be[0]);
      if (stall > 0 && cyc == stall - 1) begin
        chk({tag, "_inrdy_low"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_accepts"}, 64'(acc_cnt), 64'd2);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_b%0d", tag, ri), out_data, be[ri]);
        ri++;
      end
    end
    chk({tag, "_count"}, 64'(ri), 64'(nb));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_nodup"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00; leak_shift = '0;
    clip_val = '0; out_ready = 1'b1;
`ifdef ACT_ZERO_COUNT_EN
    zero_count_clr = 1'b0;
`endif
    #3;
    chk("rst_vld", {63'd0, out_valid}, 64'd0);
    chk("rst_dat", out_data, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_inrdy", {63'd0, in_ready}, 64'd1);

    run_one("relu", 2'b01, 3'd0, 8'd0,
            pk(-128, -1, 0, 1, 5, 127, -64, 64), pk(0, 0, 0, 1, 5, 127, 0, 64));
    run_one("bypass", 2'b00, 3'd0, 8'd0,
            pk(-128, -1, 0, 1, 5, 127, -64, 64), pk(-128, -1, 0, 1, 5, 127, -64, 64));
    run_one("leaky2", 2'b10, 3'd2, 8'd0,
            pk(-8, -1, -128, 7, -3, 0, 127, -2), pk(-2, -1, -32, 7, -1, 0, 127, -1));
    run_one("leaky0", 2'b10, 3'd0, 8'd0,
            pk(-8, -1, -128, 7, -3, 0, 127, -2), pk(-8, -1, -128, 7, -3, 0, 127, -2));
    run_one("leaky7", 2'b10, 3'd7, 8'd0,
            pk(-128, -1, -127, 1, 2, 0, -64, 100), pk(-1, -1, -1, 1, 2, 0, -1, 100));
    run_one("clip6", 2'b11, 3'd0, 8'd6,
            pk(-3, 0, 3, 6, 7, 127, -128, 5), pk(0, 0, 3, 6, 6, 6, 0, 5));
    run_one("clipneg", 2'b11, 3'd0, 8'hFB,
            pk(-3, 0, 3, 6, 7, 127, -128, 5), 64'd0);

    // Backpressure: 4 bypass beats, out_ready low for 5 cycles
    for (int k = 0; k < 4; k++) begin
      bd[k] = pk(10*k+1, 10*k+2, 10*k+3, 10*k+4, -(10*k+5), 10*k+6, 10*k+7, -(10*k+8));
      bm[k] = 2'b00; bs[k] = 3'd0; bc[k] = 8'd0; be[k] = bd[k];
    end
    stream(4, 5, "bp");

    // Per-beat mode: alternating bypass / ReLU on -5 lanes
    for (int k = 0; k < 4; k++) begin
      bd[k] = pk(-5, -5, -5, -5, -5, -5, -5, -5);
      bm[k] = (k % 2 == 0) ? 2'b00 : 2'b01;
      bs[k] = 3'd0; bc[k] = 8'd0;
      be[k] = (k % 2 == 0) ? bd[k] : 64'd0;
    end
    stream(4, 0, "pbm");

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = pk(1, 2, 3, 4, 5, 6, 7, 8); mode = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    in_data = pk(9, 9, 9, 9, 9, 9, 9, 9);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mid_full", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_dat", out_data, 64'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("no_stale%0d", k), {63'd0, out_valid}, 64'd0);
    end

`ifdef ACT_ZERO_COUNT_EN
    @(negedge clk);
    zero_count_clr = 1'b1;
    @(negedge clk);
    zero_count_clr = 1'b0;
    #1 chk("zc_init", {32'd0, zero_count}, 64'd0);
    bd[0] = pk(-1, -2, 1, 2, 3, 4, 5, 6);         be[0] = pk(0, 0, 1, 2, 3, 4, 5, 6);
    bd[1] = pk(1, 2, 3, 4, 5, 6, 7, 8);           be[1] = bd[1];
    bd[2] = pk(-1, -1, -1, -1, -1, -1, -1, -1);   be[2] = 64'd0;
    for (int k = 0; k < 3; k++) begin bm[k] = 2'b01; bs[k] = 3'd0; bc[k] = 8'd0; end
    stream(3, 0, "zc");
    chk("zc_sum", {32'd0, zero_count}, 64'd10);
    @(negedge clk);
    zero_count_clr = 1'b1;
    @(negedge clk);
    zero_count_clr = 1'b0;
    #1 chk("zc_clr", {32'd0, zero_count}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
